// File: rtl/spk_rate_encoder.sv
// Stochastic rate encoder: streams a 1024-pixel frame, emits eight 128-bit spike chunks.
// Optional macro SPK_ENC_THRESH_EN adds a thresh_mode input for deterministic thresholding.
module spk_rate_encoder #(
    parameter logic [63:0] LFSR_SEED = 64'hACE1_0F0F_1234_5678
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [63:0]  pix_in,
    input  logic         pix_valid,
`ifdef SPK_ENC_THRESH_EN
    input  logic         thresh_mode,
`endif
    output logic         pix_ready,
    output logic [127:0] spk_out,
    output logic         spk_we,
    output logic [2:0]   spk_mask,
    output logic         busy,
    output logic         frame_done
);

    localparam int unsigned PIX_W           = 8;
    localparam int unsigned PIX_PER_BEAT    = 8;
    localparam int unsigned LFSR_W          = 64;
    localparam int unsigned CHUNK_W         = 128;
    localparam int unsigned BEATS_PER_CHUNK = 16;
    localparam int unsigned CHUNKS          = 8;
    localparam int unsigned BCNT_W          = 4;
    localparam int unsigned CCNT_W          = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [BCNT_W-1:0]   bcnt;
    logic [CCNT_W-1:0]   ccnt;
    logic [LFSR_W-1:0]   lfsr;
    logic [CHUNK_W-1:0]  acc;
    logic [CHUNK_W-1:0]  acc_next;
    logic [PIX_PER_BEAT-1:0] spk_bits;
    logic                accept;
    logic                lfsr_adv;
    logic                thr_sel;

    logic                pix_ready_d;
    logic                spk_we_d;
    logic                busy_d;
    logic                frame_done_d;
    logic [CHUNK_W-1:0]  spk_out_d;
    logic [CCNT_W-1:0]   spk_mask_d;

    assign accept = pix_valid && pix_ready && (state == S_FILL);

`ifdef SPK_ENC_THRESH_EN
    assign thr_sel = thresh_mode;
`else
    assign thr_sel = 1'b0;
`endif

    // Threshold mode is deterministic and leaves the random stream untouched.
    assign lfsr_adv = accept && !thr_sel;

    // Per-pixel spike decision against the pre-step LFSR bytes.
    always_comb begin
        spk_bits = '0;
        for (int i = 0; i < int'(PIX_PER_BEAT); i++) begin
            if (thr_sel)
                spk_bits[i] = pix_in[i*PIX_W + PIX_W-1];
            else
                spk_bits[i] = pix_in[i*PIX_W +: PIX_W] > lfsr[i*PIX_W +: PIX_W];
        end
    end

    always_comb begin
        acc_next = acc;
        if (accept)
            acc_next[{bcnt, 3'b000} +: PIX_PER_BEAT] = spk_bits;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_FILL;
            S_FILL:  if (accept && (bcnt == BCNT_W'(BEATS_PER_CHUNK - 1))) state_next = S_WRITE;
            S_WRITE: state_next = (ccnt == CCNT_W'(CHUNKS - 1)) ? S_IDLE : S_FILL;
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        pix_ready_d  = (state_next == S_FILL);
        busy_d       = (state_next != S_IDLE);
        spk_we_d     = (state_next == S_WRITE);
        frame_done_d = (state_next == S_WRITE) && (ccnt == CCNT_W'(CHUNKS - 1));
        spk_out_d    = spk_out;
        spk_mask_d   = spk_mask;
        if (state_next == S_WRITE) begin
            spk_out_d  = acc_next;
            spk_mask_d = ccnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_ready  <= 1'b0;
            spk_we     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            spk_out    <= '0;
            spk_mask   <= '0;
        end else begin
            pix_ready  <= pix_ready_d;
            spk_we     <= spk_we_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
            spk_out    <= spk_out_d;
            spk_mask   <= spk_mask_d;
        end
    end

    // Datapath: beat/chunk counters, accumulator, LFSR.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt <= '0;
            ccnt <= '0;
            acc  <= '0;
            lfsr <= LFSR_SEED;
        end else begin
            acc <= acc_next;
            if (lfsr_adv)
                lfsr <= {lfsr[LFSR_W-2:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};
            if (state == S_IDLE && start) begin
                bcnt <= '0;
                ccnt <= '0;
            end else if (state == S_WRITE) begin
                bcnt <= '0;
                if (state_next == S_FILL)
                    ccnt <= ccnt + CCNT_W'(1);
            end else if (accept) begin
                bcnt <= bcnt + BCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_spk_rate_encoder.sv
// Directed bench for spk_rate_encoder; reference LFSR and spike model kept in the bench.
// Define SPK_ENC_THRESH_EN for both files to exercise the threshold mode.
`timescale 1ns/1ps
module tb_spk_rate_encoder;

    localparam logic [63:0] SEED = 64'hACE1_0F0F_1234_5678;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [63:0]  pix_in;
    logic         pix_valid;
    logic         pix_ready;
    logic [127:0] spk_out;
    logic         spk_we;
    logic [2:0]   spk_mask;
    logic         busy;
    logic         frame_done;
    bit           tb_thr = 1'b0;
`ifdef SPK_ENC_THRESH_EN
    logic         thresh_mode;
    assign thresh_mode = tb_thr;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    logic [63:0]  m_lfsr;
    logic [127:0] exp_chunk [8];
    logic [2:0]   ev_mask [$];
    logic [127:0] ev_data [$];
    int           ev_cyc  [$];
    bit           ev_done [$];

    spk_rate_encoder #(.LFSR_SEED(SEED)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
`ifdef SPK_ENC_THRESH_EN
        .thresh_mode(thresh_mode),
`endif
        .pix_ready  (pix_ready),
        .spk_out    (spk_out),
        .spk_we     (spk_we),
        .spk_mask   (spk_mask),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Chunk-write log sampled on the falling edge.
    always @(negedge clk) begin
        if (spk_we === 1'b1) begin
            ev_mask.push_back(spk_mask);
            ev_data.push_back(spk_out);
            ev_cyc.push_back(cyc);
            ev_done.push_back(frame_done === 1'b1);
        end
        if (frame_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction

    task automatic clear_log();
        ev_mask.delete();
        ev_data.delete();
        ev_cyc.delete();
        ev_done.delete();
        done_cnt = 0;
        for (int j = 0; j < 8; j++) exp_chunk[j] = '0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        pix_valid = 1'b0;
        start_cyc = cyc;
    endtask

    // mode 0: zeros, 1: random with extremes, 2: equal/above LFSR byte, 3: 128/127 alternating
    task automatic feed(input int mode, input int nbeats, input int gap_pct, input int start_at);
        int k;
        int budget;
        logic [7:0] p;
        logic [7:0] r;
        int sel;
        k = 0;
        budget = 0;
        while (k < nbeats && budget < 5000) begin
            @(negedge clk);
            start = 1'b0;
            budget++;
            if (pix_ready === 1'b1 && int'($urandom_range(99)) >= gap_pct) begin
                for (int i = 0; i < 8; i++) begin
                    r = m_lfsr[i*8 +: 8];
                    sel = int'($urandom_range(7));
                    case (mode)
                        0: p = 8'd0;
                        1: p = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom);
                        2: p = (i % 2 == 0) ? r : ((r == 8'hFF) ? 8'hFF : r + 8'd1);
                        default: p = (i % 2 == 0) ? 8'd128 : 8'd127;
                    endcase
                    pix_in[i*8 +: 8] = p;
                    exp_chunk[k/16][(k%16)*8 + i] = tb_thr ? (p >= 8'd128) : (p > r);
                end
                pix_valid = 1'b1;
                if (!tb_thr) m_lfsr = lfsr_step(m_lfsr);
                if (k == start_at) start = 1'b1;
                k++;
            end else begin
                pix_valid = (pix_ready === 1'b1) ? 1'b0 : 1'($urandom_range(1));
                pix_in = {$urandom, $urandom};
            end
        end
        @(negedge clk);
        start = 1'b0;
        pix_valid = 1'b0;
        if (k < nbeats) begin
            checks++;
            failures++;
            $display("FAIL feed_timeout beats_sent=%0d required=%0d", k, nbeats);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt < 1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        if (done_cnt < 1) begin
            checks++;
            failures++;
            $display("FAIL frame_done_timeout waited=%0d cycles", n);
        end
    endtask

    task automatic test_reset();
        bit bad;
        reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        clear_log();
        m_lfsr = SEED;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (pix_ready !== 1'b0 || busy !== 1'b0 || spk_we !== 1'b0) bad = 1'b1;
            pix_valid = 1'($urandom_range(1));
            pix_in = {$urandom, $urandom};
        end
        pix_valid = 1'b0;
        checks++; if (bad) begin failures++; $display("FAIL reset_idle_activity pix_ready/busy/spk_we seen high, required low"); end
        checks++; if (spk_out !== 128'd0) begin failures++; $display("FAIL reset_spk_out got=%h exp=0", spk_out); end
        checks++; if (spk_mask !== 3'd0) begin failures++; $display("FAIL reset_spk_mask got=%0d exp=0", spk_mask); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        checks++; if (ev_data.size() != 0) begin failures++; $display("FAIL reset_writes got=%0d exp=0", ev_data.size()); end
    endtask

    task automatic test_zero_frame();
        clear_log();
        do_start();
        feed(0, 128, 0, -1);
        wait_done();
        checks++; if (ev_data.size() != 8) begin failures++; $display("FAIL zero_write_count got=%0d exp=8", ev_data.size()); end
        for (int j = 0; j < 8 && j < ev_data.size(); j++) begin
            checks++; if (ev_mask[j] !== 3'(j)) begin failures++; $display("FAIL zero_mask[%0d] got=%0d exp=%0d", j, ev_mask[j], j); end
            checks++; if (ev_data[j] !== 128'd0) begin failures++; $display("FAIL zero_data[%0d] got=%h exp=0", j, ev_data[j]); end
            checks++; if (ev_done[j] !== (j == 7)) begin failures++; $display("FAIL zero_done_flag[%0d] got=%b exp=%b", j, ev_done[j], j == 7); end
            if (j > 0) begin
                checks++; if (ev_cyc[j] - ev_cyc[j-1] != 17) begin failures++; $display("FAIL zero_spacing[%0d] got=%0d exp=17", j, ev_cyc[j] - ev_cyc[j-1]); end
            end
        end
        checks++; if (done_cyc - start_cyc != 136) begin failures++; $display("FAIL zero_frame_time got=%0d exp=136", done_cyc - start_cyc); end
        checks++; if (busy !== 1'b0 || pix_ready !== 1'b0) begin failures++; $display("FAIL zero_end_idle busy=%b pix_ready=%b exp=0/0", busy, pix_ready); end
    endtask

    task automatic test_random_frame();
        clear_log();
        do_start();
        feed(1, 128, 35, -1);
        wait_done();
        checks++; if (ev_data.size() != 8) begin failures++; $display("FAIL rand_write_count got=%0d exp=8", ev_data.size()); end
        for (int j = 0; j < 8 && j < ev_data.size(); j++) begin
            checks++; if (ev_data[j] !== exp_chunk[j] || ev_mask[j] !== 3'(j)) begin
                failures++; $display("FAIL rand_chunk[%0d] got=%h/%0d exp=%h/%0d", j, ev_data[j], ev_mask[j], exp_chunk[j], j);
            end
        end
        checks++; if (spk_out !== exp_chunk[7] || spk_mask !== 3'd7) begin
            failures++; $display("FAIL rand_hold got=%h/%0d exp=%h/7", spk_out, spk_mask, exp_chunk[7]);
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            clear_log();
            do_start();
            feed((f == 0) ? 2 : 1, 128, 0, (f == 0) ? 20 : 127);
            wait_done();
            checks++; if (ev_data.size() != 8) begin failures++; $display("FAIL b2b_write_count[%0d] got=%0d exp=8", f, ev_data.size()); end
            checks++; if (done_cyc - start_cyc != 136) begin failures++; $display("FAIL b2b_frame_time[%0d] got=%0d exp=136", f, done_cyc - start_cyc); end
            for (int j = 0; j < 8 && j < ev_data.size(); j++) begin
                checks++; if (ev_data[j] !== exp_chunk[j] || ev_mask[j] !== 3'(j)) begin
                    failures++; $display("FAIL b2b_chunk[%0d][%0d] got=%h/%0d exp=%h/%0d", f, j, ev_data[j], ev_mask[j], exp_chunk[j], j);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        clear_log();
        do_start();
        feed(1, 40, 0, -1);
        checks++; if (busy !== 1'b1 || pix_ready !== 1'b1) begin failures++; $display("FAIL mid_stall busy=%b pix_ready=%b exp=1/1", busy, pix_ready); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || pix_ready !== 1'b0 || spk_we !== 1'b0 || frame_done !== 1'b0) begin
            failures++; $display("FAIL mid_reset_ctrl busy=%b ready=%b we=%b done=%b exp=0", busy, pix_ready, spk_we, frame_done);
        end
        checks++; if (spk_out !== 128'd0 || spk_mask !== 3'd0) begin failures++; $display("FAIL mid_reset_data got=%h/%0d exp=0/0", spk_out, spk_mask); end
        repeat (6) begin
            @(negedge clk);
            pix_valid = 1'($urandom_range(1));
            pix_in = {$urandom, $urandom};
        end
        pix_valid = 1'b0;
        checks++; if (ev_data.size() != 2) begin failures++; $display("FAIL mid_write_count got=%0d exp=2", ev_data.size()); end
        m_lfsr = SEED;
        clear_log();
        do_start();
        feed(2, 128, 10, -1);
        wait_done();
        checks++; if (ev_data.size() != 8) begin failures++; $display("FAIL post_reset_write_count got=%0d exp=8", ev_data.size()); end
        for (int j = 0; j < 8 && j < ev_data.size(); j++) begin
            checks++; if (ev_data[j] !== exp_chunk[j]) begin failures++; $display("FAIL post_reset_chunk[%0d] got=%h exp=%h", j, ev_data[j], exp_chunk[j]); end
        end
    endtask

    task automatic test_start_with_reset();
        clear_log();
        @(negedge clk);
        start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        m_lfsr = SEED;
        checks++; if (busy !== 1'b0 || pix_ready !== 1'b0) begin failures++; $display("FAIL start_reset_idle busy=%b ready=%b exp=0/0", busy, pix_ready); end
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0 || ev_data.size() != 0) begin failures++; $display("FAIL start_reset_later busy=%b writes=%0d exp=0/0", busy, ev_data.size()); end
    endtask

`ifdef SPK_ENC_THRESH_EN
    task automatic test_thresh();
        logic [63:0] lfsr_before;
        lfsr_before = m_lfsr;
        tb_thr = 1'b1;
        clear_log();
        do_start();
        feed(3, 128, 20, -1);
        wait_done();
        tb_thr = 1'b0;
        checks++; if (ev_data.size() != 8) begin failures++; $display("FAIL thr_write_count got=%0d exp=8", ev_data.size()); end
        for (int j = 0; j < 8 && j < ev_data.size(); j++) begin
            checks++; if (ev_data[j] !== {16{8'h55}}) begin failures++; $display("FAIL thr_chunk[%0d] got=%h exp=5555..5555", j, ev_data[j]); end
        end
        m_lfsr = lfsr_before;
        clear_log();
        do_start();
        feed(2, 128, 0, -1);
        wait_done();
        for (int j = 0; j < 8 && j < ev_data.size(); j++) begin
            checks++; if (ev_data[j] !== exp_chunk[j]) begin failures++; $display("FAIL thr_lfsr_kept_chunk[%0d] got=%h exp=%h", j, ev_data[j], exp_chunk[j]); end
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        start = 1'b0;
        pix_valid = 1'b0;
        pix_in = '0;
        test_reset();
        test_zero_frame();
        test_random_frame();
        test_back_to_back();
        test_reset_midframe();
        test_start_with_reset();
`ifdef SPK_ENC_THRESH_EN
        test_thresh();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spk_rate_encoder.md
# spk_rate_encoder

Stochastic rate encoder feeding the input-layer spike register of the spike processor. Accepts a streamed 1024-pixel frame of 8-bit intensities, 8 pixels per beat. Converts each pixel to one spike bit by comparing it against a 64-bit LFSR. Packs the bits into eight 128-bit chunks and writes each chunk through the processor's `input_128n_spk_in` / `_we` / `_mask` load port, one frame per timestep.

## Interface
- `LFSR_SEED`, default 64'hACE1_0F0F_1234_5678: LFSR value after reset; must be nonzero.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that begins encoding of one frame; honoured only in IDLE.
- `pix_in` in 64: 8 pixels; pixel i = `pix_in[8i+7:8i]`.
- `pix_valid` in 1: `pix_in` valid.
- `pix_ready` out 1: encoder accepts a beat; a beat transfers when `pix_valid && pix_ready`.
- `spk_out` out 128: chunk data, connects to `input_128n_spk_in`.
- `spk_we` out 1: chunk write strobe, connects to `input_128n_spk_in_we`.
- `spk_mask` out 3: chunk index, connects to `input_128n_spk_in_mask`.
- `busy` out 1: frame in progress.
- `frame_done` out 1: one-cycle pulse when the last chunk is written.

## Operation
- States: IDLE, FILL, WRITE.
- IDLE:
  - `pix_ready`=0.
  - `start` → FILL; beat counter b=0, chunk counter c=0.
  - `start` outside IDLE is ignored.
- FILL:
  - `pix_ready`=1.
  - Each accepted beat: for i in 0..7, `acc[b*8+i] <= (pix_i > lfsr[8i+7:8i])`. The comparison is strict, unsigned, and uses the LFSR value before its step.
  - The LFSR then steps once.
  - b increments. On the accept with b=15 → WRITE.
- WRITE (one cycle):
  - `spk_we`=1, `spk_out`=acc, `spk_mask`=c.
  - If c=7: `frame_done`=1 → IDLE.
  - Otherwise: c++, b=0 → FILL.
- Pixel mapping: global index = c*128 + b*8 + i.
- LFSR:
  - 64-bit Fibonacci, polynomial x^64+x^63+x^61+x^60+1.
  - Step: `lfsr <= {lfsr[62:0], lfsr[63]^lfsr[62]^lfsr[60]^lfsr[59]}`.
  - Advances only on accepted beats.
  - Not reseeded by `start`, so successive frames (timesteps) draw fresh random numbers. Only `reset` reloads `LFSR_SEED`.
- Intensity semantics: pixel 0 never spikes; pixel 255 spikes unless its random byte is 255; expected density is p/256.
- `busy`=1 in FILL and WRITE.

## Timing
- Reset values:
  - `pix_ready`, `spk_we`, `spk_mask`, `busy`, `frame_done` = 0.
  - `spk_out`=0; acc=0; lfsr=`LFSR_SEED`; state IDLE.
- All outputs are registered. `spk_out` and `spk_mask` hold their last written value outside WRITE.
- `start` sampled at cycle t → FILL and `pix_ready`=1 at t+1.
- Beat accepted at t with b=15 → `spk_we`=1 at t+1; `pix_ready`=0 at t+1, which is one bubble per chunk.
- Minimum frame time: 136 cycles from first FILL cycle to `frame_done` (128 beats + 8 write cycles).
- `pix_valid` low stalls FILL indefinitely, with no LFSR step and no state change.
- `pix_in` is ignored whenever `pix_ready`=0.
- `reset` mid-frame:
  - Next cycle is IDLE with all outputs at reset values.
  - The partial chunk is discarded and no further `spk_we` is issued.
  - `reset` wins over `start` in the same cycle.

## Configuration
- `SPK_ENC_THRESH_EN` defined:
  - Adds input port `thresh_mode` (1 bit, sampled per accepted beat).
  - When `thresh_mode`=1: spike = (pix_i >= 128), deterministic, and the LFSR does not step on that beat.
  - When `thresh_mode`=0: stochastic behaviour as above.
- Undefined: no `thresh_mode` port; always stochastic.

## Test plan
- Reset then idle 20 cycles → all outputs 0, `pix_ready`=0, no `spk_we`.
- `start`, 128 beats of all-zero pixels with `pix_valid` held high → 8 `spk_we` pulses, 17 cycles apart, with masks 0..7 in order; `spk_out`=0 each time; `frame_done` coincides with mask 7; 136 cycles total.
- Random pixels with random `pix_valid` gaps → `spk_out` per chunk matches a bit-exact model (same seed and LFSR); LFSR steps exactly 128 times per frame.
- `reset` asserted after 40 accepted beats → only 2 `spk_we` pulses were issued; a following `start` yields a clean frame whose first random byte equals the seed's.
- `start` pulsed while busy, and `start`+`reset` in the same cycle → no effect on the frame in progress; after reset the block is in IDLE.
- With `SPK_ENC_THRESH_EN`, `thresh_mode`=1, pixels alternating 128/127 → every chunk `spk_out` = 128'h5555…5555 and the LFSR is unchanged after the frame.
